// File: rtl/memory_stage.sv
// memory_stage: pipeline stage between execute and write-back of the 16-bit core.
// Registers the EX result and control, runs one data-memory access per instruction
// over a req/ack port (load, store, push, pop), owns the stack pointer and hands
// exactly one result per instruction to WB.
//
// Optional build macro: STACK_GUARD_EN
//   When defined, adds output stack_err and blocks pushes at SP==0 and pops at
//   SP==SP_RESET. The blocked instruction skips memory and retires with
//   out_reg_write=0.
//   When undefined, SP wraps modulo 2^ADDR_W.
//
// Ports
//   clk, rst                    clock, synchronous active-low reset
//   in_valid / in_ready         instruction handshake from EX
//   alu_out, store_data         EX result / address and write data
//   mem_read, mem_write,
//   push, pop                   memory operation flags
//                               (priority push > pop > mem_write > mem_read)
//   reg_write, rdst             register write-back control
//   dm_req, dm_we, dm_addr,
//   dm_wdata                    data-memory request, held until dm_ack
//   dm_rdata, dm_ack            data-memory response
//   out_valid, out_data,
//   out_rdst, out_reg_write     one-cycle result to WB
//   stack_err                   guard violation pulse (STACK_GUARD_EN only)
//   sp                          current stack pointer
module memory_stage #(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] SP_RESET = ADDR_W'(16'hFFFF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] store_data,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              push,
  input  logic              pop,
  input  logic              reg_write,
  input  logic [2:0]        rdst,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  input  logic              dm_ack,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        out_rdst,
  output logic              out_reg_write,
`ifdef STACK_GUARD_EN
  output logic              stack_err,
`endif
  output logic [ADDR_W-1:0] sp
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
  typedef enum logic [2:0] {OP_NONE, OP_PUSH, OP_POP, OP_WR, OP_RD} op_t;

  state_t            r_state, w_state_nxt;
  op_t               r_op, w_op_nxt, w_op_dec;
  logic [ADDR_W-1:0] r_sp, w_sp_nxt;
  logic              r_in_ready, w_in_ready_nxt;
  logic              r_dm_req, w_dm_req_nxt;
  logic              r_dm_we, w_dm_we_nxt;
  logic [ADDR_W-1:0] r_dm_addr, w_dm_addr_nxt;
  logic [DATA_W-1:0] r_dm_wdata, w_dm_wdata_nxt;
  logic              r_out_valid, w_out_valid_nxt;
  logic [DATA_W-1:0] r_out_data, w_out_data_nxt;
  logic [2:0]        r_out_rdst, w_out_rdst_nxt;
  logic              r_out_reg_write, w_out_reg_write_nxt;
  logic              r_reg_write, w_reg_write_nxt;
  logic [DATA_W-1:0] r_alu, w_alu_nxt;
  logic              w_accept;
  logic              w_guard;
`ifdef STACK_GUARD_EN
  logic              r_stack_err, w_stack_err_nxt;
`endif

  // r_in_ready mirrors "state is IDLE", so it doubles as the accept qualifier
  assign w_accept = in_valid & r_in_ready;

  // Operation decode with fixed priority; lower-priority flags are dropped
  always_comb begin
    w_op_dec = OP_NONE;
    if (push)           w_op_dec = OP_PUSH;
    else if (pop)       w_op_dec = OP_POP;
    else if (mem_write) w_op_dec = OP_WR;
    else if (mem_read)  w_op_dec = OP_RD;
  end

  // Stack guard: an overflowing push or underflowing pop never reaches memory
  always_comb begin
    w_guard = 1'b0;
`ifdef STACK_GUARD_EN
    w_guard = ((w_op_dec == OP_PUSH) && (r_sp == '0)) ||
              ((w_op_dec == OP_POP)  && (r_sp == SP_RESET));
`endif
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt         = r_state;
    w_op_nxt            = r_op;
    w_sp_nxt            = r_sp;
    w_dm_req_nxt        = r_dm_req;
    w_dm_we_nxt         = r_dm_we;
    w_dm_addr_nxt       = r_dm_addr;
    w_dm_wdata_nxt      = r_dm_wdata;
    w_out_valid_nxt     = 1'b0;
    w_out_data_nxt      = r_out_data;
    w_out_rdst_nxt      = r_out_rdst;
    w_out_reg_write_nxt = 1'b0;
    w_reg_write_nxt     = r_reg_write;
    w_alu_nxt           = r_alu;
`ifdef STACK_GUARD_EN
    w_stack_err_nxt     = 1'b0;
`endif

    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_op_nxt        = w_op_dec;
          w_alu_nxt       = alu_out;
          w_reg_write_nxt = reg_write;
          w_out_rdst_nxt  = rdst;
          if ((w_op_dec == OP_NONE) || w_guard) begin
            // No memory work: retire straight from RESP next cycle
            w_state_nxt         = S_RESP;
            w_out_valid_nxt     = 1'b1;
            w_out_data_nxt      = alu_out;
            w_out_reg_write_nxt = reg_write & ~w_guard;
`ifdef STACK_GUARD_EN
            w_stack_err_nxt     = w_guard;
`endif
          end else begin
            w_state_nxt    = S_ACCESS;
            w_dm_req_nxt   = 1'b1;
            w_dm_we_nxt    = (w_op_dec == OP_PUSH) || (w_op_dec == OP_WR);
            w_dm_wdata_nxt = store_data;
            unique case (w_op_dec)
              OP_PUSH: w_dm_addr_nxt = r_sp;
              OP_POP:  w_dm_addr_nxt = r_sp + ADDR_W'(1);
              default: w_dm_addr_nxt = ADDR_W'(alu_out);
            endcase
          end
        end
      end
      S_ACCESS: begin
        // Request fields stay frozen until the ack
        if (dm_ack) begin
          w_state_nxt         = S_RESP;
          w_dm_req_nxt        = 1'b0;
          w_out_valid_nxt     = 1'b1;
          w_out_reg_write_nxt = r_reg_write;
          if ((r_op == OP_RD) || (r_op == OP_POP)) w_out_data_nxt = dm_rdata;
          else                                    w_out_data_nxt = r_alu;
          if (r_op == OP_PUSH)     w_sp_nxt = r_sp - ADDR_W'(1);
          else if (r_op == OP_POP) w_sp_nxt = r_sp + ADDR_W'(1);
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    w_in_ready_nxt = (w_state_nxt == S_IDLE);
  end

  // State and output registers; reset abandons any in-flight access
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state         <= S_IDLE;
      r_op            <= OP_NONE;
      r_sp            <= SP_RESET;
      r_in_ready      <= 1'b1;
      r_dm_req        <= 1'b0;
      r_dm_we         <= 1'b0;
      r_dm_addr       <= '0;
      r_dm_wdata      <= '0;
      r_out_valid     <= 1'b0;
      r_out_data      <= '0;
      r_out_rdst      <= '0;
      r_out_reg_write <= 1'b0;
      r_reg_write     <= 1'b0;
      r_alu           <= '0;
`ifdef STACK_GUARD_EN
      r_stack_err     <= 1'b0;
`endif
    end else begin
      r_state         <= w_state_nxt;
      r_op            <= w_op_nxt;
      r_sp            <= w_sp_nxt;
      r_in_ready      <= w_in_ready_nxt;
      r_dm_req        <= w_dm_req_nxt;
      r_dm_we         <= w_dm_we_nxt;
      r_dm_addr       <= w_dm_addr_nxt;
      r_dm_wdata      <= w_dm_wdata_nxt;
      r_out_valid     <= w_out_valid_nxt;
      r_out_data      <= w_out_data_nxt;
      r_out_rdst      <= w_out_rdst_nxt;
      r_out_reg_write <= w_out_reg_write_nxt;
      r_reg_write     <= w_reg_write_nxt;
      r_alu           <= w_alu_nxt;
`ifdef STACK_GUARD_EN
      r_stack_err     <= w_stack_err_nxt;
`endif
    end
  end

  assign in_ready      = r_in_ready;
  assign dm_req        = r_dm_req;
  assign dm_we         = r_dm_we;
  assign dm_addr       = r_dm_addr;
  assign dm_wdata      = r_dm_wdata;
  assign out_valid     = r_out_valid;
  assign out_data      = r_out_data;
  assign out_rdst      = r_out_rdst;
  assign out_reg_write = r_out_reg_write;
  assign sp            = r_sp;
`ifdef STACK_GUARD_EN
  assign stack_err     = r_stack_err;
`endif

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed cases followed by randomized instructions,
// checked against a transaction-level model of SP, op priority and a sparse memory.
module tb_memory_stage;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 16;
  localparam logic [15:0] SP_RST = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] alu_out, store_data;
  logic        mem_read, mem_write, push, pop, reg_write;
  logic [2:0]  rdst;
  logic        dm_req, dm_we;
  logic [15:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_ack;
  logic        out_valid;
  logic [15:0] out_data;
  logic [2:0]  out_rdst;
  logic        out_reg_write;
  logic [15:0] sp;
`ifdef STACK_GUARD_EN
  logic        stack_err;
`endif

  always #5 clk = ~clk;

  memory_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SP_RESET(SP_RST)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .store_data(store_data), .mem_read(mem_read),
    .mem_write(mem_write), .push(push), .pop(pop), .reg_write(reg_write),
    .rdst(rdst), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .out_valid(out_valid), .out_data(out_data), .out_rdst(out_rdst),
    .out_reg_write(out_reg_write),
`ifdef STACK_GUARD_EN
    .stack_err(stack_err),
`endif
    .sp(sp)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state: stack pointer and sparse data memory
  logic [15:0] m_sp;
  logic [15:0] mem [int];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return a ^ 16'h5A5A;
  endfunction

  // One instruction from accept to retirement; entered and left on a negedge.
  // dly = idle ACCESS cycles before the ack; spur = stray ack while idle.
  task automatic txn(input logic f_push, input logic f_pop, input logic f_mw,
                     input logic f_mr, input logic [15:0] alu, input logic [15:0] sd,
                     input logic rw, input logic [2:0] rd, input int dly,
                     input logic spur);
    int          op;
    logic        guard, is_mem, e_we;
    logic [15:0] e_addr, e_data;
    op = f_push ? 1 : f_pop ? 2 : f_mw ? 3 : f_mr ? 4 : 0;
    guard = 1'b0;
`ifdef STACK_GUARD_EN
    guard = (op == 1 && m_sp == 16'h0000) || (op == 2 && m_sp == SP_RST);
`endif
    is_mem = (op != 0) && !guard;
    e_we   = (op == 1) || (op == 3);
    e_addr = (op == 1) ? m_sp : (op == 2) ? m_sp + 16'd1 : alu;
    e_data = alu;

    check("in_ready_idle", 16'(in_ready), 16'd1);
    in_valid = 1'b1; push = f_push; pop = f_pop; mem_write = f_mw; mem_read = f_mr;
    alu_out = alu; store_data = sd; reg_write = rw; rdst = rd;
    dm_ack = spur; dm_rdata = 16'hDEAD;
    @(negedge clk);
    in_valid = 1'b0; push = 1'b0; pop = 1'b0; mem_write = 1'b0; mem_read = 1'b0;
    dm_ack = 1'b0;

    if (is_mem) begin
      for (int c = 0; c <= dly; c++) begin
        check("dm_req_hold", 16'(dm_req), 16'd1);
        check("dm_we", 16'(dm_we), 16'(e_we));
        check("dm_addr", dm_addr, e_addr);
        if (e_we) check("dm_wdata", dm_wdata, sd);
        check("in_ready_busy", 16'(in_ready), 16'd0);
        check("no_early_valid", 16'(out_valid), 16'd0);
        if (c == dly) begin
          dm_ack   = 1'b1;
          dm_rdata = e_we ? 16'($urandom) : mem_rd(dm_addr);
        end
        @(negedge clk);
      end
      dm_ack = 1'b0;
      if (!e_we) e_data = mem_rd(e_addr);
      else       mem[int'(e_addr)] = sd;
      if (op == 1) m_sp = m_sp - 16'd1;
      if (op == 2) m_sp = m_sp + 16'd1;
      check("dm_req_drop", 16'(dm_req), 16'd0);
    end else begin
      check("no_req", 16'(dm_req), 16'd0);
    end

    check("out_valid", 16'(out_valid), 16'd1);
    check("out_data", out_data, e_data);
    check("out_rdst", 16'(out_rdst), 16'(rd));
    check("out_reg_write", 16'(out_reg_write), 16'(rw & ~guard));
    check("sp", sp, m_sp);
`ifdef STACK_GUARD_EN
    check("stack_err", 16'(stack_err), 16'(guard));
`endif
    @(negedge clk);
    check("out_valid_pulse", 16'(out_valid), 16'd0);
    check("out_reg_write_idle", 16'(out_reg_write), 16'd0);
`ifdef STACK_GUARD_EN
    check("stack_err_pulse", 16'(stack_err), 16'd0);
`endif
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; alu_out = '0; store_data = '0;
    mem_read = 1'b0; mem_write = 1'b0; push = 1'b0; pop = 1'b0;
    reg_write = 1'b0; rdst = '0; dm_rdata = '0; dm_ack = 1'b0;
    m_sp = SP_RST;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sp", sp, SP_RST);
    check("rst_dm_req", 16'(dm_req), 16'd0);
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_out_reg_write", 16'(out_reg_write), 16'd0);
    rst = 1'b1;
    @(negedge clk);

    // No-op passthrough
    txn(1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000, 1'b1, 3'd3, 0, 1'b0);
    // Load with ack three cycles after the request
    mem[int'(16'h0040)] = 16'hBEEF;
    txn(1'b0, 1'b0, 1'b0, 1'b1, 16'h0040, 16'h0000, 1'b1, 3'd5, 3, 1'b0);
    // Push then pop from reset
    txn(1'b1, 1'b0, 1'b0, 1'b0, 16'h0007, 16'hAAAA, 1'b0, 3'd0, 0, 1'b0);
    check("sp_after_push", sp, 16'hFFFE);
    txn(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 3'd2, 1, 1'b0);
    check("pop_data_value", out_data, 16'hAAAA);
    // Priority: push wins over pop and read; write wins over read
    txn(1'b1, 1'b1, 1'b0, 1'b1, 16'h0100, 16'h5555, 1'b0, 3'd1, 0, 1'b0);
    txn(1'b0, 1'b0, 1'b1, 1'b1, 16'h0200, 16'h6666, 1'b0, 3'd4, 2, 1'b0);
    txn(1'b0, 1'b0, 1'b0, 1'b1, 16'h0200, 16'h0000, 1'b1, 3'd6, 0, 1'b1);
    // Restore SP to reset value through a pop
    txn(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 3'd7, 0, 1'b0);

    // Reset in the middle of an access, ack arriving afterwards
    txn(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1111, 1'b0, 3'd0, 0, 1'b0);
    in_valid = 1'b1; mem_read = 1'b1; alu_out = 16'h0300; reg_write = 1'b1; rdst = 3'd2;
    @(negedge clk);
    in_valid = 1'b0; mem_read = 1'b0;
    check("rst_mid_req", 16'(dm_req), 16'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; dm_ack = 1'b1; dm_rdata = 16'hCAFE;
    m_sp = SP_RST;
    check("rst_mid_drop", 16'(dm_req), 16'd0);
    check("rst_mid_ready", 16'(in_ready), 16'd1);
    check("rst_mid_sp", sp, SP_RST);
    @(negedge clk);
    dm_ack = 1'b0;
    check("late_ack_ignored", 16'(out_valid), 16'd0);
    check("late_ack_sp", sp, SP_RST);
    @(negedge clk);
    check("late_ack_quiet", 16'(out_valid), 16'd0);

    // Pop at empty stack (blocked with the guard, wraps to 0000 without it)
    txn(1'b0, 1'b1, 1'b0, 1'b0, 16'h0042, 16'h0000, 1'b1, 3'd1, 0, 1'b0);
`ifndef STACK_GUARD_EN
    check("pop_wrap_sp", sp, 16'h0000);
    // Push at 0000 writes there and wraps SP back to FFFF
    txn(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h7777, 1'b0, 3'd0, 0, 1'b0);
    check("push_wrap_sp", sp, 16'hFFFF);
`else
    check("guard_sp", sp, SP_RST);
`endif

    // Randomized instructions
    for (int i = 0; i < 200; i++) begin
      int          sel;
      logic [15:0] a;
      sel = int'($urandom_range(0, 9));
      a   = 16'($urandom_range(0, 15)) << 4;
      txn(sel == 0 || sel == 1, sel == 2 || sel == 3 || ($urandom_range(0, 3) == 0),
          sel == 4 || ($urandom_range(0, 3) == 0), sel == 5 || sel == 6,
          (sel >= 7) ? 16'($urandom) : a, 16'($urandom), 1'($urandom),
          3'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Hard stop so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
